// File: rtl/tvla_capture_sequencer.sv
// rtl/tvla_capture_sequencer.sv - fixed-vs-random TVLA capture campaign sequencer
// Drives scope trigger, AES start/class select and campaign status pins.
module tvla_capture_sequencer #(
  parameter int unsigned NUM_TRACES   = 10000,
  parameter int unsigned GAP_CYCLES   = 1000,
  parameter int unsigned TRIG_PRE     = 2,
  parameter int unsigned WAIT_TIMEOUT = 4096,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic        aes_ready,
  input  logic        aes_done,
  output logic        aes_start,
  output logic        aes_fix_sel,
  output logic        trigger_pin,
  output logic        output_fix,
  output logic        done_signal,
  output logic        error,
  output logic [19:0] trace_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        abort_q, abort_d;
  logic        start_q, start_d;
  logic        fix_q, fix_d;
  logic        trig_q, trig_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [19:0] count_q, count_d;
  logic [31:0] count_ext;

  assign count_ext = {12'd0, count_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    abort_d = abort_q;
    start_d = 1'b0;
    fix_d   = fix_q;
    trig_d  = trig_q;
    done_d  = done_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (enable && !done_q && !err_q) begin
          state_d = S_ARM;
          cnt_d   = 32'd0;
          trig_d  = 1'b1;
        end
      end
      S_ARM: begin
        if (!enable) begin
          state_d = S_IDLE;
          trig_d  = 1'b0;
        end else if (cnt_q == TRIG_PRE - 1) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_START: begin
        if (!enable) begin
          state_d = S_IDLE;
          trig_d  = 1'b0;
        end else if (aes_ready) begin
          // Class is taken from the LFSR before it advances, once per trace.
          state_d = S_WAIT;
          cnt_d   = 32'd0;
          start_d = 1'b1;
          fix_d   = lfsr_q[0];
          lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
          abort_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          abort_d = 1'b1;
        end
        if (aes_done) begin
          state_d = S_POST;
        end else if (cnt_q == WAIT_TIMEOUT - 1) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          trig_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_POST: begin
        trig_d = 1'b0;
        if (count_ext < NUM_TRACES) begin
          count_d = count_q + 20'd1;
        end
        if (count_ext + 32'd1 >= NUM_TRACES) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (abort_q || !enable) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          cnt_d   = 32'd0;
        end
      end
      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == GAP_CYCLES - 1) begin
          state_d = S_ARM;
          cnt_d   = 32'd0;
          trig_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        trig_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        trig_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      lfsr_q  <= LFSR_SEED;
      abort_q <= 1'b0;
      start_q <= 1'b0;
      fix_q   <= 1'b0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 20'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      abort_q <= abort_d;
      start_q <= start_d;
      fix_q   <= fix_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign aes_start   = start_q;
  assign aes_fix_sel = fix_q;
  assign output_fix  = fix_q;
  assign trigger_pin = trig_q;
  assign done_signal = done_q;
  assign error       = err_q;
  assign trace_count = count_q;

endmodule

// File: tb/tb_tvla_capture_sequencer.sv
// tb/tb_tvla_capture_sequencer.sv - self-checking bench for tvla_capture_sequencer
// Table-driven first traces plus campaign, abort, timeout and reset sequences.
module tb_tvla_capture_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rdy_a, done_a, start_a, fix_a, trig_a, ofix_a, dsig_a, err_a;
  logic [19:0] cnt_a;
  logic rst_b, en_b, rdy_b, done_b, start_b, fix_b, trig_b, ofix_b, dsig_b, err_b;
  logic [19:0] cnt_b;

  tvla_capture_sequencer #(.NUM_TRACES(4), .GAP_CYCLES(3), .TRIG_PRE(2),
                           .WAIT_TIMEOUT(64), .LFSR_SEED(16'hACE1)) dut_a (
    .CLK(clk), .RST(rst_a), .enable(en_a), .aes_ready(rdy_a), .aes_done(done_a),
    .aes_start(start_a), .aes_fix_sel(fix_a), .trigger_pin(trig_a),
    .output_fix(ofix_a), .done_signal(dsig_a), .error(err_a), .trace_count(cnt_a));

  tvla_capture_sequencer #(.NUM_TRACES(8), .GAP_CYCLES(1), .TRIG_PRE(1),
                           .WAIT_TIMEOUT(8), .LFSR_SEED(16'hACE1)) dut_b (
    .CLK(clk), .RST(rst_b), .enable(en_b), .aes_ready(rdy_b), .aes_done(done_b),
    .aes_start(start_b), .aes_fix_sel(fix_b), .trigger_pin(trig_b),
    .output_fix(ofix_b), .done_signal(dsig_b), .error(err_b), .trace_count(cnt_b));

  typedef struct {
    logic        en;
    logic        rdy;
    logic        done;
    logic        trig;
    logic        start;
    logic [19:0] cnt;
    int          lead;
  } vec_t;

  vec_t tbl [18];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int rise_a = 0;
  int prev_start_a = 0;
  int exp_lead = 3;
  int starts_a = 0;
  int starts_b = 0;
  int cd_a = 0;
  int cd_b = 0;
  bit have_prev = 0;
  bit spacing_on = 0;
  bit last_start_a = 0;
  bit last_trig_a = 0;
  bit auto_a = 0;
  bit auto_b = 0;
  logic [15:0] model_lfsr;
  logic q_a [$];
  logic q_b [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    // Taps 16,14,13,11 map to bit indices 0,2,3,5 in a right-shifting register.
    logic fb;
    fb = x[0] ^ x[2] ^ x[3] ^ x[5];
    return {fb, x[15:1]};
  endfunction

  // One clock: sample outputs, score start events, then run the AES models.
  task automatic step();
    logic e;
    @(posedge clk);
    #1;
    cyc++;
    if (trig_a && !last_trig_a) rise_a = cyc;
    if (start_a) begin
      starts_a++;
      chk("a_no_double_start", {31'd0, last_start_a}, 0);
      chk("a_trig_at_start", {31'd0, trig_a}, 1);
      chk("a_trig_lead", cyc - rise_a, exp_lead);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_fix_sel", {31'd0, fix_a}, {31'd0, e});
        chk("a_output_fix", {31'd0, ofix_a}, {31'd0, e});
      end else begin
        total_cnt++;
        $display("FAIL a_unexpected_start: got start at cycle %0d expected none", cyc);
      end
      if (spacing_on && have_prev) chk("a_trace_spacing", cyc - prev_start_a, 17);
      prev_start_a = cyc;
      have_prev = 1;
    end
    last_start_a = start_a;
    last_trig_a = trig_a;
    if (auto_a) begin
      if (start_a) cd_a = 10;
      else if (cd_a > 0) cd_a--;
      done_a = (cd_a == 1);
    end
    if (start_b) begin
      starts_b++;
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b_fix_sel", {31'd0, fix_b}, {31'd0, e});
        chk("b_output_fix", {31'd0, ofix_b}, {31'd0, e});
      end else begin
        total_cnt++;
        $display("FAIL b_unexpected_start: got start at cycle %0d expected none", cyc);
      end
    end
    if (auto_b) begin
      if (start_b) cd_b = 3;
      else if (cd_b > 0) cd_b--;
      done_b = (cd_b == 1);
    end
  endtask

  initial begin
    bit seen;
    rst_a = 1; rst_b = 1;
    en_a = 0; en_b = 0;
    rdy_a = 1; rdy_b = 1;
    done_a = 0; done_b = 0;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0, 3};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 20'd0, 3};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0, 3};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 20'd0, 3};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0, 3};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 20'd0, 3};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'd1, 3};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'd1, 3};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'd1, 3};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd1, 3};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd1, 3};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd1, 3};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd1, 3};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd1, 3};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd1, 3};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd1, 3};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd1, 3};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 20'd1, 8};

    step();
    step();
    chk("a_reset_outputs", {6'd0, trig_a, start_a, fix_a, ofix_a, dsig_a, err_a, cnt_a}, 0);
    chk("b_reset_outputs", {6'd0, trig_b, start_b, fix_b, ofix_b, dsig_b, err_b, cnt_b}, 0);
    rst_a = 0; rst_b = 0;
    step();
    chk("a_idle_without_enable", {31'd0, trig_a}, 0);

    // Class sequence over 8 traces on the short-latency instance.
    model_lfsr = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      q_b.push_back(model_lfsr[0]);
      model_lfsr = lfsr_next(model_lfsr);
    end
    auto_b = 1;
    en_b = 1;
    for (int i = 0; i < 600 && !dsig_b; i++) step();
    chk("b_done", {31'd0, dsig_b}, 1);
    chk("b_count", {12'd0, cnt_b}, 8);
    chk("b_starts", starts_b, 8);
    chk("b_queue_left", q_b.size(), 0);
    chk("b_no_error", {31'd0, err_b}, 0);

    // Timeout: AES never completes.
    rst_b = 1;
    auto_b = 0; cd_b = 0; done_b = 0;
    step();
    chk("b_reset_after_run", {6'd0, trig_b, start_b, fix_b, ofix_b, dsig_b, err_b, cnt_b}, 0);
    rst_b = 0;
    model_lfsr = 16'hACE1;
    q_b.push_back(model_lfsr[0]);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = start_b;
    end
    chk("b_timeout_start_seen", {31'd0, seen}, 1);
    repeat (7) step();
    chk("b_no_error_early", {31'd0, err_b}, 0);
    chk("b_trig_held_in_wait", {31'd0, trig_b}, 1);
    step();
    chk("b_timeout_error", {31'd0, err_b}, 1);
    chk("b_timeout_trig", {31'd0, trig_b}, 0);
    chk("b_timeout_done_low", {31'd0, dsig_b}, 0);
    chk("b_timeout_count", {12'd0, cnt_b}, 0);
    repeat (10) step();
    chk("b_timeout_sticky", {30'd0, err_b, trig_b}, 2);
    chk("b_timeout_no_restart", starts_b, 9);

    // First two traces cycle by cycle, including ignored aes_done and a ready stall.
    model_lfsr = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(model_lfsr[0]);
      model_lfsr = lfsr_next(model_lfsr);
    end
    for (int i = 0; i < 18; i++) begin
      en_a = tbl[i].en;
      rdy_a = tbl[i].rdy;
      done_a = tbl[i].done;
      exp_lead = tbl[i].lead;
      step();
      chk($sformatf("row%0d_trig", i), {31'd0, trig_a}, {31'd0, tbl[i].trig});
      chk($sformatf("row%0d_start", i), {31'd0, start_a}, {31'd0, tbl[i].start});
      chk($sformatf("row%0d_count", i), {12'd0, cnt_a}, {12'd0, tbl[i].cnt});
    end
    done_a = 0; rdy_a = 1; exp_lead = 3;

    // Abort in WAIT of trace 2: trace completes, then IDLE.
    en_a = 0;
    repeat (3) step();
    chk("abort_trace_continues", {31'd0, trig_a}, 1);
    done_a = 1;
    step();
    done_a = 0;
    chk("abort_post_trig", {31'd0, trig_a}, 1);
    step();
    chk("abort_trig_drop", {31'd0, trig_a}, 0);
    chk("abort_count", {12'd0, cnt_a}, 2);
    repeat (6) step();
    chk("abort_idle_trig", {31'd0, trig_a}, 0);
    chk("abort_idle_count", {12'd0, cnt_a}, 2);
    chk("abort_starts", starts_a, 2);
    chk("abort_done_low", {31'd0, dsig_a}, 0);

    // Resume with the autonomous AES model.
    auto_a = 1; cd_a = 0; spacing_on = 1; have_prev = 0;
    en_a = 1;
    for (int i = 0; i < 300 && !dsig_a; i++) step();
    chk("resume_done", {31'd0, dsig_a}, 1);
    chk("resume_count", {12'd0, cnt_a}, 4);
    chk("resume_starts", starts_a, 4);
    chk("resume_queue_left", q_a.size(), 0);
    chk("resume_no_error", {31'd0, err_a}, 0);
    repeat (30) step();
    chk("done_sticky", {31'd0, dsig_a}, 1);
    chk("done_no_more_starts", starts_a, 4);
    chk("done_count_saturated", {12'd0, cnt_a}, 4);

    // Reset mid-campaign, then a full campaign from count 0.
    en_a = 0; rst_a = 1;
    step();
    rst_a = 0;
    chk("a_reset_after_done", {6'd0, trig_a, start_a, fix_a, ofix_a, dsig_a, err_a, cnt_a}, 0);
    q_a.delete();
    model_lfsr = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(model_lfsr[0]);
      model_lfsr = lfsr_next(model_lfsr);
    end
    have_prev = 0;
    en_a = 1;
    for (int i = 0; i < 200 && starts_a < 6; i++) step();
    chk("mid_second_start_seen", starts_a, 6);
    step();
    step();
    chk("mid_trig_before_reset", {31'd0, trig_a}, 1);
    chk("mid_count_before_reset", {12'd0, cnt_a}, 1);
    rst_a = 1;
    step();
    chk("mid_reset_outputs", {6'd0, trig_a, start_a, fix_a, ofix_a, dsig_a, err_a, cnt_a}, 0);
    rst_a = 0;
    cd_a = 0; done_a = 0; have_prev = 0;
    q_a.delete();
    model_lfsr = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(model_lfsr[0]);
      model_lfsr = lfsr_next(model_lfsr);
    end
    for (int i = 0; i < 300 && !dsig_a; i++) step();
    chk("restart_done", {31'd0, dsig_a}, 1);
    chk("restart_count", {12'd0, cnt_a}, 4);
    chk("restart_starts", starts_a, 10);
    chk("restart_queue_left", q_a.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
